// File: rtl/nanov_gpio_bank.sv
// nanov_gpio_bank: memory-mapped GPIO bank for the nanoV bus.
// Optional GPIO_IRQ_EN macro adds the IRQ_EN register and irq output.
module nanov_gpio_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h10000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             cpu_clk,
  input  logic             rst,
  input  logic             is_addr,
  input  logic [31:0]      addr_out,
  input  logic             is_data,
  input  logic [31:0]      data_out,
  output logic [31:0]      data_in,
  output logic             sel,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
`ifdef GPIO_IRQ_EN
  output logic             irq,
`endif
  output logic [WIDTH-1:0] gpio_oe
);

  localparam logic [3:0] R_OUT  = 4'd0;
  localparam logic [3:0] R_IN   = 4'd1;
  localparam logic [3:0] R_DIR  = 4'd2;
  localparam logic [3:0] R_SET  = 4'd3;
  localparam logic [3:0] R_CLR  = 4'd4;
  localparam logic [3:0] R_TGL  = 4'd5;
  localparam logic [3:0] R_RISE = 4'd6;
  localparam logic [3:0] R_FALL = 4'd7;
`ifdef GPIO_IRQ_EN
  localparam logic [3:0] R_IRQ  = 4'd8;
  localparam logic [3:0] R_LAST = R_IRQ;
`else
  localparam logic [3:0] R_LAST = R_FALL;
`endif
  localparam logic [2:0] ARM_N = 3'(SYNC_STAGES + 1);

  logic             sel_q, sel_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       arm_q, arm_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
`endif

  logic [31:0]      off;
  logic             hit;
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] in_w;
  logic             armed;
  logic [WIDTH-1:0] rise_new, fall_new;
  logic [WIDTH-1:0] clr_rise, clr_fall;
  logic [31:0]      rd;
  logic             unused_data;

  assign unused_data = ^data_out;

  // Address decode: latch the register index on every address phase
  always_comb begin
    off   = addr_out - BASE_ADDR;
    hit   = (off[1:0] == 2'b00) && (off[31:2] <= 30'(R_LAST));
    sel_d = sel_q;
    idx_d = idx_q;
    if (is_addr) begin
      sel_d = hit;
      idx_d = hit ? off[5:2] : 4'd0;
    end
  end

  assign wr   = is_data && sel_q;
  assign wd   = data_out[WIDTH-1:0];
  assign in_w = sync_q[SYNC_STAGES-1];

  // Input synchroniser, edge detection and arm counter
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], gpio_in};
    prev_d   = in_w;
    armed    = (arm_q == ARM_N);
    arm_d    = armed ? arm_q : arm_q + 3'd1;
    rise_new = armed ? (in_w & ~prev_q) : '0;
    fall_new = armed ? (~in_w & prev_q) : '0;
  end

  // Register writes; a fresh edge beats a same-cycle W1C
  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    clr_rise = '0;
    clr_fall = '0;
`ifdef GPIO_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    if (wr) begin
      unique case (1'b1)
        idx_q == R_OUT:  out_d    = wd;
        idx_q == R_DIR:  dir_d    = wd;
        idx_q == R_SET:  out_d    = out_q | wd;
        idx_q == R_CLR:  out_d    = out_q & ~wd;
        idx_q == R_TGL:  out_d    = out_q ^ wd;
        idx_q == R_RISE: clr_rise = wd;
        idx_q == R_FALL: clr_fall = wd;
`ifdef GPIO_IRQ_EN
        idx_q == R_IRQ:  irq_en_d = wd;
`endif
        default: ;
      endcase
    end
    rise_d = (rise_q & ~clr_rise) | rise_new;
    fall_d = (fall_q & ~clr_fall) | fall_new;
  end

`ifdef GPIO_IRQ_EN
  // Interrupt request from enabled sticky status
  always_comb begin
    irq_d = |((rise_q | fall_q) & irq_en_q);
  end
`endif

  // Read mux, zero-extended, idle when unselected
  always_comb begin
    rd = '0;
    if (sel_q) begin
      unique case (1'b1)
        idx_q == R_OUT:  rd[WIDTH-1:0] = out_q;
        idx_q == R_IN:   rd[WIDTH-1:0] = in_w;
        idx_q == R_DIR:  rd[WIDTH-1:0] = dir_q;
        idx_q == R_SET:  rd[WIDTH-1:0] = out_q;
        idx_q == R_CLR:  rd[WIDTH-1:0] = out_q;
        idx_q == R_TGL:  rd[WIDTH-1:0] = out_q;
        idx_q == R_RISE: rd[WIDTH-1:0] = rise_q;
        idx_q == R_FALL: rd[WIDTH-1:0] = fall_q;
`ifdef GPIO_IRQ_EN
        idx_q == R_IRQ:  rd[WIDTH-1:0] = irq_en_q;
`endif
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      sel_q    <= 1'b0;
      idx_q    <= '0;
      out_q    <= '0;
      dir_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      prev_q   <= '0;
      arm_q    <= '0;
      sync_q   <= '0;
`ifdef GPIO_IRQ_EN
      irq_en_q <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      dir_q    <= dir_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      prev_q   <= prev_d;
      arm_q    <= arm_d;
      sync_q   <= sync_d;
`ifdef GPIO_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

  assign data_in  = rd;
  assign sel      = sel_q;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
`ifdef GPIO_IRQ_EN
  assign irq      = irq_q;
`endif

endmodule

// File: tb/tb_nanov_gpio_bank.sv
// tb_nanov_gpio_bank: scoreboard bench for nanov_gpio_bank.
// Expected values are queued at stimulus time and popped at compare.
module tb_nanov_gpio_bank;

  localparam logic [31:0] BASE = 32'h10000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_addr = 1'b0;
  logic [31:0] addr_out = '0;
  logic        is_data = 1'b0;
  logic [31:0] data_out = '0;
  logic [31:0] data_in;
  logic        sel;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
`ifdef GPIO_IRQ_EN
  logic        irq;
`endif

  logic [31:0] exp_q[$];
  logic [31:0] got, e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  nanov_gpio_bank #(
    .WIDTH(8),
    .BASE_ADDR(BASE),
    .SYNC_STAGES(2)
  ) dut (
    .cpu_clk(clk),
    .rst(rst),
    .is_addr(is_addr),
    .addr_out(addr_out),
    .is_data(is_data),
    .data_out(data_out),
    .data_in(data_in),
    .sel(sel),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
`ifdef GPIO_IRQ_EN
    .irq(irq),
`endif
    .gpio_oe(gpio_oe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel_reg(input logic [31:0] off);
    is_addr  = 1'b1;
    addr_out = BASE + off;
    tick();
    is_addr  = 1'b0;
    addr_out = '0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    sel_reg(off);
    is_data  = 1'b1;
    data_out = d;
    tick();
    is_data  = 1'b0;
    data_out = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gpio_in = 8'hFF;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    tick();
    tick();
    got = {24'h0, gpio_out}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_out got=%h exp=%h", got, e); end
    got = {24'h0, gpio_oe}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_oe got=%h exp=%h", got, e); end
    got = {31'h0, sel}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_sel got=%h exp=%h", got, e); end
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_din got=%h exp=%h", got, e); end
    rst = 1'b0;
    repeat (6) tick();
    exp_q.push_back(32'h00);
    sel_reg(32'h18);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_rise got=%h exp=%h", got, e); end
    exp_q.push_back(32'hFF);
    sel_reg(32'h04);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_in got=%h exp=%h", got, e); end
    gpio_in = 8'h00;
    repeat (4) tick();
    exp_q.push_back(32'hFF);
    sel_reg(32'h1C);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_fall_set got=%h exp=%h", got, e); end
    exp_q.push_back(32'h00);
    wr(32'h1C, 32'hFF);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL fall_w1c got=%h exp=%h", got, e); end
  endtask

  task automatic test_out_alias();
    logic [31:0] offs [4];
    logic [31:0] dats [4];
    logic [31:0] outs [4];
    offs = '{32'h00, 32'h0C, 32'h10, 32'h14};
    dats = '{32'hA5, 32'h0F, 32'hA0, 32'hFF};
    outs = '{32'hA5, 32'hAF, 32'h0F, 32'hF0};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(outs[i]);
      exp_q.push_back(outs[i]);
      wr(offs[i], dats[i]);
      got = {24'h0, gpio_out}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL alias_out[%0d] got=%h exp=%h", i, got, e); end
      got = data_in; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL alias_rd[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_input_edge();
    sel_reg(32'h04);
    gpio_in = 8'h81;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h81);
    exp_q.push_back(32'h81);
    tick();
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL in_lat1 got=%h exp=%h", got, e); end
    tick();
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL in_lat2 got=%h exp=%h", got, e); end
    sel_reg(32'h18);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rise_lat3 got=%h exp=%h", got, e); end
    gpio_in = 8'h80;
    repeat (4) tick();
    exp_q.push_back(32'h01);
    sel_reg(32'h1C);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL fall_bit0 got=%h exp=%h", got, e); end
    exp_q.push_back(32'h81);
    sel_reg(32'h18);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rise_keep got=%h exp=%h", got, e); end
  endtask

  task automatic test_w1c_race();
    gpio_in = 8'h81;
    exp_q.push_back(32'h01);
    tick();
    wr(32'h18, 32'h81);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL w1c_race got=%h exp=%h", got, e); end
  endtask

  task automatic test_unmapped();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hF0);
    exp_q.push_back(32'h00);
    wr(32'h24, 32'hFF);
    got = {31'h0, sel}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL unmap_sel got=%h exp=%h", got, e); end
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL unmap_din got=%h exp=%h", got, e); end
    got = {24'h0, gpio_out}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL unmap_out got=%h exp=%h", got, e); end
    got = {24'h0, gpio_oe}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL unmap_oe got=%h exp=%h", got, e); end
`ifndef GPIO_IRQ_EN
    exp_q.push_back(32'h0);
    sel_reg(32'h20);
    got = {31'h0, sel}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL unmap20_sel got=%h exp=%h", got, e); end
`endif
    exp_q.push_back(32'h0);
    sel_reg(32'hFFFFFFFC);
    got = {31'h0, sel}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL below_sel got=%h exp=%h", got, e); end
    exp_q.push_back(32'h3C);
    exp_q.push_back(32'h3C);
    wr(32'h08, 32'h3C);
    got = {24'h0, gpio_oe}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL dir_oe got=%h exp=%h", got, e); end
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL dir_rd got=%h exp=%h", got, e); end
  endtask

  task automatic test_back_to_back();
    sel_reg(32'h00);
    is_addr  = 1'b1;
    addr_out = BASE + 32'h08;
    is_data  = 1'b1;
    data_out = 32'h55;
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h3C);
    exp_q.push_back(32'h3C);
    tick();
    is_addr  = 1'b0;
    got = {24'h0, gpio_out}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL b2b_out got=%h exp=%h", got, e); end
    got = {24'h0, gpio_oe}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL b2b_oe got=%h exp=%h", got, e); end
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL b2b_rd got=%h exp=%h", got, e); end
    data_out = 32'h0F;
    exp_q.push_back(32'h0F);
    tick();
    is_data  = 1'b0;
    data_out = '0;
    got = {24'h0, gpio_oe}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL b2b_next got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset_abort();
    sel_reg(32'h00);
    rst      = 1'b1;
    is_data  = 1'b1;
    data_out = 32'hAA;
    tick();
    rst      = 1'b0;
    data_out = 32'hFF;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h0);
    tick();
    is_data  = 1'b0;
    data_out = '0;
    got = {24'h0, gpio_out}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL abort_out got=%h exp=%h", got, e); end
    got = {31'h0, sel}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL abort_sel got=%h exp=%h", got, e); end
    repeat (6) tick();
    exp_q.push_back(32'h00);
    sel_reg(32'h18);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL arm_rise got=%h exp=%h", got, e); end
    exp_q.push_back(32'h81);
    sel_reg(32'h04);
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL arm_in got=%h exp=%h", got, e); end
  endtask

`ifdef GPIO_IRQ_EN
  task automatic test_irq();
    gpio_in = 8'h00;
    repeat (5) tick();
    wr(32'h1C, 32'hFF);
    wr(32'h20, 32'h01);
    exp_q.push_back(32'h01);
    exp_q.push_back(32'h0);
    tick();
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL irqen_rd got=%h exp=%h", got, e); end
    got = {31'h0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL irq_idle got=%h exp=%h", got, e); end
    gpio_in = 8'h02;
    exp_q.push_back(32'h0);
    repeat (5) tick();
    got = {31'h0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL irq_masked got=%h exp=%h", got, e); end
    sel_reg(32'h18);
    gpio_in = 8'h03;
    exp_q.push_back(32'h03);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    repeat (3) tick();
    got = data_in; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL irq_rise got=%h exp=%h", got, e); end
    got = {31'h0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL irq_lag got=%h exp=%h", got, e); end
    tick();
    got = {31'h0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL irq_set got=%h exp=%h", got, e); end
    is_data  = 1'b1;
    data_out = 32'h01;
    tick();
    is_data  = 1'b0;
    data_out = '0;
    got = {31'h0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL irq_hold got=%h exp=%h", got, e); end
    tick();
    got = {31'h0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL irq_clr got=%h exp=%h", got, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_out_alias();
    test_input_edge();
    test_w1c_race();
    test_unmapped();
    test_back_to_back();
    test_reset_abort();
`ifdef GPIO_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
